// File: rtl/timer_ctrl_pkg.sv
// Shared FSM state type and encoding for the timer controller.
package timer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/timer_ctrl_counter_en_Nbit.sv
// Up-counter with synchronous clear and enable.
// Used for both the main count and the prescaler.
module counter_en_Nbit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] count
);

  logic [N-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + N'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/pause timer with one-shot or auto-reload terminal count.
// Optional prescaler is built when TIMER_CTRL_PRESCALE_EN is defined.
//
//   state | meaning
//   IDLE  | stopped, count held at 0
//   RUN   | counting enables towards the captured limit
//   DONE  | one-shot finished, count held at limit until start/stop
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [N-1:0]     limit,
`ifdef TIMER_CTRL_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [N-1:0]     count,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  state_t         state_q, state_d;
  logic           periodic_q, periodic_d;
  logic [N-1:0]   limit_q, limit_d;
  logic           tick_q, tick_d;
  logic [N-1:0]   count_w;
  logic           accept, en, at_limit, running;

  assign running  = (state_q == RUN);
  // Start is only honoured outside RUN; stop always wins.
  assign accept   = start && !stop && !running;
  assign at_limit = (count_w == limit_q);

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_cnt;
  logic             pre_match;

  assign pre_match = (pre_cnt == prescale_q);
  assign en        = running && !pause && pre_match;

  counter_en_Nbit #(.N(PRE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || stop || en),
    .en    (running && !pause && !pre_match),
    .count (pre_cnt)
  );
`else
  assign en = running && !pause;
`endif

  counter_en_Nbit #(.N(N)) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (stop || accept || (en && at_limit && periodic_q)),
    .en    (en && !at_limit),
    .count (count_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      periodic_q <= 1'b0;
      limit_q    <= '0;
      tick_q     <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
      prescale_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      periodic_q <= periodic_d;
      limit_q    <= limit_d;
      tick_q     <= tick_d;
`ifdef TIMER_CTRL_PRESCALE_EN
      prescale_q <= prescale_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    periodic_d = periodic_q;
    limit_d    = limit_q;
    tick_d     = 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
    prescale_d = prescale_q;
`endif
    if (stop) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d    = RUN;
      periodic_d = periodic;
      limit_d    = limit;
`ifdef TIMER_CTRL_PRESCALE_EN
      prescale_d = prescale;
`endif
    end else if (en && at_limit) begin
      tick_d = 1'b1;
      if (!periodic_q) state_d = DONE;
    end
  end

  assign count = count_w;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign tick  = tick_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed + randomized bench for timer_ctrl against an elapsed-time reference model.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, periodic;
  logic [3:0] limit;
`ifdef TIMER_CTRL_PRESCALE_EN
  logic [7:0] prescale;
`endif
  logic [3:0] count;
  logic       busy, done, tick;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 run, 2 done; m_el counts unpaused RUN cycles since start.
  int m_mode = 0;
  int m_el   = 0;
  int m_per  = 0;
  int m_lim  = 0;
  int m_pre  = 0;
  int m_tick = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.N(4), .PRE_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .limit    (limit),
`ifdef TIMER_CTRL_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tick     (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int cur_prescale();
`ifdef TIMER_CTRL_PRESCALE_EN
    return int'(prescale);
`else
    return 0;
`endif
  endfunction

  task automatic model_edge(input logic rs, input logic st, input logic sp, input logic ps);
    m_tick = 0;
    if (rs) begin
      m_mode = 0; m_el = 0; m_per = 0; m_lim = 0; m_pre = 0;
    end else if (sp) begin
      m_mode = 0; m_el = 0;
    end else if (st && m_mode != 1) begin
      m_mode = 1; m_el = 0;
      m_per = int'(periodic); m_lim = int'(limit); m_pre = cur_prescale();
    end else if (m_mode == 1 && !ps) begin
      m_el++;
      if (m_el % ((m_lim + 1) * (m_pre + 1)) == 0) begin
        m_tick = 1;
        if (m_per == 0) m_mode = 2;
      end
    end
  endtask

  function automatic int model_count();
    if (m_mode == 1) return (m_el / (m_pre + 1)) % (m_lim + 1);
    if (m_mode == 2) return m_lim;
    return 0;
  endfunction

  task automatic step(input logic rs, input logic st, input logic sp, input logic ps);
    reset = rs; start = st; stop = sp; pause = ps;
    @(posedge clk);
    model_edge(rs, st, sp, ps);
    #1;
    chk("count", 32'(count), 32'(model_count()));
    chk("busy",  32'(busy),  32'(m_mode == 1));
    chk("done",  32'(done),  32'(m_mode == 2));
    chk("tick",  32'(tick),  32'(m_tick));
  endtask

  int c029[6];
  int d029[6];
  int t029[6];

  initial begin
    c029[0] = 0; c029[1] = 1; c029[2] = 2; c029[3] = 3; c029[4] = 3; c029[5] = 3;
    d029[0] = 0; d029[1] = 0; d029[2] = 0; d029[3] = 0; d029[4] = 1; d029[5] = 1;
    t029[0] = 0; t029[1] = 0; t029[2] = 0; t029[3] = 0; t029[4] = 1; t029[5] = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; limit = '0;
`ifdef TIMER_CTRL_PRESCALE_EN
    prescale = '0;
`endif
    #2;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // One-shot, limit 3: fixed expected sequence independent of the model
    periodic = 1'b0; limit = 4'd3;
    for (int i = 0; i < 6; i++) begin
      step(0, i == 0, 0, 0);
      chk("os_count", 32'(count), 32'(c029[i]));
      chk("os_done",  32'(done),  32'(d029[i]));
      chk("os_tick",  32'(tick),  32'(t029[i]));
      limit = 4'd9;
    end

    // Start in DONE re-arms; start in RUN ignored; start+stop resolves to stop
    limit = 4'd5; periodic = 1'b1;
    step(0, 1, 0, 0);
    chk("rearm_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("startstop_busy", 32'(busy), 32'd0);
    step(0, 0, 0, 0);

    // Reset held two cycles mid-RUN
    limit = 4'd2; periodic = 1'b1;
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Pause for three cycles at count 1 in a periodic run
    limit = 4'd3; periodic = 1'b1;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("pause_at1", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Limit 0 periodic: tick every cycle from the second RUN cycle
    limit = 4'd0; periodic = 1'b1;
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      limit    = 4'($urandom_range(0, 15));
      periodic = 1'($urandom_range(0, 1));
`ifdef TIMER_CTRL_PRESCALE_EN
      prescale = 8'($urandom_range(0, 3));
`endif
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
